// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, main FSM encoding
// and the GF(2^8) / ShiftRows / MixColumns helpers.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_INIT        = 3'd1,
        ST_KEY_ADD     = 3'd2,
        ST_SUB_BYTES   = 3'd3,
        ST_SHIFT_ROWS  = 3'd4,
        ST_MIX_COLUMNS = 3'd5,
        ST_DONE        = 3'd6
    } aes_state_e;

    function automatic logic [7:0] gm2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] a);
        return gm2(a) ^ a;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gm2(a0) ^ gm3(a1) ^ a2 ^ a3,
                a0 ^ gm2(a1) ^ gm3(a2) ^ a3,
                a0 ^ a1 ^ gm2(a2) ^ gm3(a3),
                gm3(a0) ^ a1 ^ a2 ^ gm2(a3)};
    endfunction

    function automatic logic [127:0] mixcols(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mixw(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // Byte (row r, column c) sits at index 4c+r, MSB first.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_gen.sv
// AES-128 key expansion: one round key per cycle after init,
// all eleven kept so any round can be read while ready.
module aes_key_gen
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [127:0] key_i,
    input  logic         keylen_i,
    input  logic         init_i,
    input  logic [3:0]   round_i,
    output logic [127:0] round_key_o,
    output logic         ready_o
);

    logic [127:0] rk_q [0:NUM_ROUNDS];
    logic [127:0] last_q;
    logic [3:0]   cnt_q;
    logic [7:0]   rcon_q;
    logic         run_q;
    logic         ready_q;
    logic [31:0]  sub_w;
    logic [31:0]  t_w, n0_w, n1_w, n2_w, n3_w;

    aes_sbox_word u_sbox (
        .word_i ({last_q[23:0], last_q[31:24]}),
        .word_o (sub_w)
    );

    assign t_w  = sub_w ^ {rcon_q, 24'h0};
    assign n0_w = last_q[127:96] ^ t_w;
    assign n1_w = last_q[95:64] ^ n0_w;
    assign n2_w = last_q[63:32] ^ n1_w;
    assign n3_w = last_q[31:0] ^ n2_w;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk_q[i] <= '0;
            end
            last_q  <= '0;
            cnt_q   <= '0;
            rcon_q  <= '0;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
        end else if (init_i) begin
            rk_q[0] <= key_i;
            last_q  <= key_i;
            cnt_q   <= 4'd1;
            rcon_q  <= 8'h01;
            run_q   <= 1'b1;
            ready_q <= 1'b0;
        end else if (run_q) begin
            rk_q[cnt_q] <= {n0_w, n1_w, n2_w, n3_w};
            last_q      <= {n0_w, n1_w, n2_w, n3_w};
            rcon_q      <= gm2(rcon_q);
            cnt_q       <= cnt_q + 4'd1;
            if (cnt_q == LAST_ROUND) begin
                run_q   <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

    // Only the 128-bit schedule exists; a longer key never reports ready.
    assign ready_o     = ready_q & ~keylen_i;
    assign round_key_o = (round_i <= LAST_ROUND) ? rk_q[round_i] : '0;

endmodule

// File: rtl/aes_sbox_word.sv
// Combinational forward AES S-box applied to the four bytes
// of a 32-bit word.
module aes_sbox_word (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                     SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes_encryption_core.sv
// Iterative AES-128 cipher: one S-box word per cycle,
// 72 cycles from accepted start to ciphertext.
module aes_encryption_core
    import aes_pkg::*;
(
    input  logic         aclk,
    input  logic         areset,
    input  logic [127:0] key,
    input  logic         key_init,
    output logic         key_ready,
    input  logic         next,
    input  logic [127:0] input_block,
    output logic [127:0] output_block,
    output logic         block_ready,
    output logic         busy
);

    aes_state_e   fsm_q;
    logic [127:0] st_q;
    logic [3:0]   round_q;
    logic [1:0]   wc_q;
    logic [127:0] out_q;
    logic         brdy_q;

    logic [127:0] rkey_w;
    logic [31:0]  sb_in_w;
    logic [31:0]  sb_out_w;
    logic [127:0] sub_st_w;

    aes_key_gen u_key_gen (
        .clk_i       (aclk),
        .rst_i       (areset),
        .key_i       (key),
        .keylen_i    (1'b0),
        .init_i      (key_init && (fsm_q == ST_IDLE)),
        .round_i     (round_q),
        .round_key_o (rkey_w),
        .ready_o     (key_ready)
    );

    aes_sbox_word u_sbox (
        .word_i (sb_in_w),
        .word_o (sb_out_w)
    );

    always_comb begin
        sb_in_w = st_q[127:96];
        unique case (wc_q)
            2'd0: sb_in_w = st_q[127:96];
            2'd1: sb_in_w = st_q[95:64];
            2'd2: sb_in_w = st_q[63:32];
            2'd3: sb_in_w = st_q[31:0];
        endcase
    end

    always_comb begin
        sub_st_w = st_q;
        unique case (wc_q)
            2'd0: sub_st_w[127:96] = sb_out_w;
            2'd1: sub_st_w[95:64]  = sb_out_w;
            2'd2: sub_st_w[63:32]  = sb_out_w;
            2'd3: sub_st_w[31:0]   = sb_out_w;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            fsm_q   <= ST_IDLE;
            st_q    <= '0;
            round_q <= '0;
            wc_q    <= '0;
            out_q   <= '0;
            brdy_q  <= 1'b0;
        end else begin
            brdy_q <= 1'b0;
            unique case (fsm_q)
                ST_IDLE: begin
                    if (next && key_ready) begin
                        fsm_q <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    st_q    <= input_block;
                    round_q <= '0;
                    fsm_q   <= ST_KEY_ADD;
                end
                ST_KEY_ADD: begin
                    st_q <= st_q ^ rkey_w;
                    if (round_q == LAST_ROUND) begin
                        fsm_q <= ST_DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                        wc_q    <= '0;
                        fsm_q   <= ST_SUB_BYTES;
                    end
                end
                ST_SUB_BYTES: begin
                    st_q <= sub_st_w;
                    wc_q <= wc_q + 2'd1;
                    if (wc_q == 2'd3) begin
                        fsm_q <= ST_SHIFT_ROWS;
                    end
                end
                ST_SHIFT_ROWS: begin
                    st_q  <= shiftrows(st_q);
                    fsm_q <= (round_q == LAST_ROUND) ? ST_KEY_ADD
                                                     : ST_MIX_COLUMNS;
                end
                ST_MIX_COLUMNS: begin
                    st_q  <= mixcols(st_q);
                    fsm_q <= ST_KEY_ADD;
                end
                ST_DONE: begin
                    out_q  <= st_q;
                    brdy_q <= 1'b1;
                    fsm_q  <= ST_IDLE;
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign output_block = out_q;
    assign block_ready  = brdy_q;
    assign busy         = (fsm_q != ST_IDLE);

endmodule
